// File: rtl/shift_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb_pkg
// Purpose  : Shared types and constants for the shift_arb_seq sequencer and
//            its single-pass shift step.
// Contents : state_e  - sequencer FSM state encoding (IDLE/RUN/DONE)
//            MODE_LSR - logical shift right, zero fill
//            MODE_ROR - rotate right
//            MAX_STEP - largest amount the shared shifter moves per pass
// Revision : 1.0 - initial release
// ============================================================================
package shift_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_LSR = 1'b0;
    localparam logic MODE_ROR = 1'b1;

    localparam int MAX_STEP = 3;

endpackage : shift_arb_pkg
`default_nettype wire

// File: rtl/shift_arb_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb_seq_if
// Purpose  : Request/response bundle between the ALU-side requesters and the
//            shift_arb_seq sequencer.
// Signals  : req_valid[N_REQ]       per-requester job valid
//            req_ready[N_REQ]       one-hot accept pulse in the grant cycle
//            req_data[4*N_REQ]      operands, requester i at [4i+3:4i]
//            req_amt[AMT_W*N_REQ]   shift amounts, requester i at slice i
//            req_mode[N_REQ]        0 = logical shift right, 1 = rotate right
//            rsp_valid / rsp_ready  response handshake
//            rsp_data[4]            result
//            rsp_id[ID_W]           owner of the result
// Modports : master - requester/consumer side
//            slave  - sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface shift_arb_seq_if
    import shift_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AMT_W = 4,
    parameter int ID_W  = 1
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [4*N_REQ-1:0]     req_data;
    logic [AMT_W*N_REQ-1:0] req_amt;
    logic [N_REQ-1:0]       req_mode;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [3:0]             rsp_data;
    logic [ID_W-1:0]        rsp_id;

    modport master (
        output req_valid, req_data, req_amt, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface : shift_arb_seq_if
`default_nettype wire

// File: rtl/shift_step4.sv
`default_nettype none
// ============================================================================
// Module   : shift_step4
// Purpose  : One pass of the shared 4-bit right shifter (amount 0..3).
// Ports    : in[3:0]  operand
//            s[1:0]   shift amount for this pass
//            mode     MODE_LSR = zero-fill shift, MODE_ROR = rotate
//            out[3:0] shifted / rotated operand
// Revision : 1.0 - initial release
// ============================================================================
module shift_step4
    import shift_arb_pkg::*;
(
    input  logic [3:0] in,
    input  logic [1:0] s,
    input  logic       mode,
    output logic [3:0] out
);

    // Shifting a doubled copy right leaves the rotated nibble in the low
    // half; s = 0 naturally passes the operand through.
    logic [7:0] rot_wide;

    always_comb begin
        rot_wide = {in, in} >> s;
        if (mode == MODE_ROR) begin
            out = rot_wide[3:0];
        end else begin
            out = in >> s;
        end
    end

endmodule : shift_step4
`default_nettype wire

// File: rtl/shift_arb_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb_seq
// Purpose  : Round-robin arbiter and multi-pass sequencer in front of the
//            shared 4-bit shifter. A granted job is executed as repeated
//            passes of at most MAX_STEP positions, then returned with the
//            owner's index over a valid/ready response channel.
// Ports    : clk    system clock, rising edge
//            rst_n  asynchronous active-low reset
//            bus    shift_arb_seq_if.slave (request and response channels)
//            busy   high while a job is in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
module shift_arb_seq
    import shift_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AMT_W = 4,
    parameter int ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_arb_seq_if.slave        bus,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_q,    rr_d;
    logic [ID_W-1:0]  id_q,    id_d;
    logic [3:0]       data_q,  data_d;
    logic [AMT_W-1:0] rem_q,   rem_d;
    logic             mode_q,  mode_d;

    // ------------------------------------------------------------------
    // Per-requester views of the packed request buses
    // ------------------------------------------------------------------
    logic [3:0]       data_arr [N_REQ];
    logic [AMT_W-1:0] amt_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[4*i +: 4];
        assign amt_arr[i]  = bus.req_amt[AMT_W*i +: AMT_W];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: scan from the farthest offset back to the pointer
    // so the candidate closest to rr_q is the one left standing.
    // ------------------------------------------------------------------
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand_idx;
    int               cand_sum;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        cand_sum    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_sum = int'(rr_q) + k;
            if (cand_sum >= N_REQ) begin
                cand_sum = cand_sum - N_REQ;
            end
            cand_idx = ID_W'(cand_sum);
            if (bus.req_valid[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // One shifter pass per RUN cycle
    // ------------------------------------------------------------------
    logic [1:0] step;
    logic [3:0] step_out;

    assign step = (rem_q > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem_q[1:0];

    shift_step4 u_step (
        .in   (data_q),
        .s    (step),
        .mode (mode_q),
        .out  (step_out)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_LSR;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    id_d   = grant_idx;
                    data_d = data_arr[grant_idx];
                    rem_d  = amt_arr[grant_idx];
                    mode_d = bus.req_mode[grant_idx];
                    state_d = (amt_arr[grant_idx] == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                data_d = step_out;
                rem_d  = rem_q - AMT_W'(step);
                if (rem_q <= AMT_W'(MAX_STEP)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Returning to IDLE here means the earliest next grant is
                // the following cycle, never the handshake cycle itself.
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    if (int'(id_q) == N_REQ - 1) begin
                        rr_d = '0;
                    end else begin
                        rr_d = id_q + ID_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.req_ready = '0;
        // Qualified by rst_n so no accept pulse leaks out while reset is
        // held with requests pending.
        if (rst_n && (state_q == IDLE) && grant_valid) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
        bus.rsp_valid = (state_q == DONE);
        bus.rsp_data  = data_q;
        bus.rsp_id    = id_q;
        busy          = (state_q != IDLE);
    end

endmodule : shift_arb_seq
`default_nettype wire
